// File: rtl/input_debouncer_if.sv
// Conditioned-input bundle between the board pins and the debouncer.
// The slave side is the debouncer; the master side is whoever drives pins and consumes events.
interface input_debouncer_if #(
    parameter int unsigned WIDTH = 6
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output raw_in,
        input  level,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  raw_in,
        output level,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer, polarity normalization and per-bit debounce for KEY/SW pins.
// Emits clean active-high levels plus registered one-cycle rise/fall/changed events.
module input_debouncer #(
    parameter int unsigned      WIDTH        = 6,
    parameter int unsigned      STABLE_COUNT = 1000000,
    parameter logic [WIDTH-1:0] INVERT_MASK  = 6'b000011
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input_debouncer_if.slave  bus
);
    localparam int unsigned   CW     = (STABLE_COUNT < 1) ? 1 : $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] THRESH = CW'(STABLE_COUNT - 1);

    logic [WIDTH-1:0]         sync1_r;
    logic [WIDTH-1:0]         sync2_r;
    logic [WIDTH-1:0]         sample_s;
    logic [WIDTH-1:0]         level_r;
    logic [WIDTH-1:0]         rise_r;
    logic [WIDTH-1:0]         fall_r;
    logic                     changed_r;
    logic [WIDTH-1:0][CW-1:0] count_r;

    logic [WIDTH-1:0]         level_n_s;
    logic [WIDTH-1:0]         rise_n_s;
    logic [WIDTH-1:0]         fall_n_s;
    logic                     changed_n_s;
    logic [WIDTH-1:0][CW-1:0] count_n_s;

    // Synchronizer resets to the inactive pin level so idle inputs normalize to 0.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_r <= INVERT_MASK;
            sync2_r <= INVERT_MASK;
        end else begin
            sync1_r <= bus.raw_in;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r ^ INVERT_MASK;

    // Per-bit debounce decision: clear on agreement, commit at threshold, else count up.
    always_comb begin
        level_n_s = level_r;
        rise_n_s  = {WIDTH{1'b0}};
        fall_n_s  = {WIDTH{1'b0}};
        count_n_s = count_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (sample_s[i] == level_r[i]) begin
                count_n_s[i] = {CW{1'b0}};
            end else if (count_r[i] == THRESH) begin
                level_n_s[i] = sample_s[i];
                rise_n_s[i]  = sample_s[i];
                fall_n_s[i]  = ~sample_s[i];
                count_n_s[i] = {CW{1'b0}};
            end else begin
                count_n_s[i] = count_r[i] + CW'(1);
            end
        end
        changed_n_s = |(rise_n_s | fall_n_s);
    end

    // Debounce state and event registers; events last exactly one cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            level_r   <= {WIDTH{1'b0}};
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
            count_r   <= {(WIDTH*CW){1'b0}};
        end else begin
            level_r   <= level_n_s;
            rise_r    <= rise_n_s;
            fall_r    <= fall_n_s;
            changed_r <= changed_n_s;
            count_r   <= count_n_s;
        end
    end

    assign bus.level   = level_r;
    assign bus.rise    = rise_r;
    assign bus.fall    = fall_r;
    assign bus.changed = changed_r;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_COUNT = 4, WIDTH = 6, KEY bits active-low.
module tb_input_debouncer;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    input_debouncer_if #(.WIDTH(6)) bus ();

    input_debouncer #(
        .WIDTH        (6),
        .STABLE_COUNT (4),
        .INVERT_MASK  (6'b000011)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed {level,rise,fall,changed}=%h expected %h", tag, obs, exp);
    endtask

    function automatic logic [18:0] outs_s();
        return {bus.level, bus.rise, bus.fall, bus.changed};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [5:0] lvl, input logic [5:0] r,
                                input logic [5:0] f, input logic c);
        tick();
        chk(tag, outs_s(), {lvl, r, f, c});
    endtask

    task automatic hold(input string tag, input int n, input logic [5:0] lvl);
        for (int k = 0; k < n; k++) begin
            expect_cycle(tag, lvl, 6'b000000, 6'b000000, 1'b0);
        end
    endtask

    initial begin
        bus.raw_in = 6'b000011;

        // reset and idle
        hold("in_reset", 3, 6'b000000);
        reset = 1'b0;
        hold("idle", 20, 6'b000000);

        // clean key press and release on KEY0 (active-low)
        bus.raw_in = 6'b000010;
        hold("press_wait", 5, 6'b000000);
        expect_cycle("press_edge6", 6'b000001, 6'b000001, 6'b000000, 1'b1);
        expect_cycle("press_after", 6'b000001, 6'b000000, 6'b000000, 1'b0);
        hold("press_hold", 3, 6'b000001);
        bus.raw_in = 6'b000011;
        hold("release_wait", 5, 6'b000001);
        expect_cycle("release_edge6", 6'b000000, 6'b000000, 6'b000001, 1'b1);
        expect_cycle("release_after", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        // bounce rejection on SW0 (bit 2)
        for (int b = 0; b < 5; b++) begin
            bus.raw_in = 6'b000111;
            hold("bounce_hi", 3, 6'b000000);
            bus.raw_in = 6'b000011;
            hold("bounce_lo", 3, 6'b000000);
        end
        bus.raw_in = 6'b000111;
        hold("bounce_settle", 5, 6'b000000);
        expect_cycle("bounce_rise", 6'b000100, 6'b000100, 6'b000000, 1'b1);
        expect_cycle("bounce_after", 6'b000100, 6'b000000, 6'b000000, 1'b0);
        bus.raw_in = 6'b000011;
        hold("sw0_off_wait", 5, 6'b000100);
        expect_cycle("sw0_fall", 6'b000000, 6'b000000, 6'b000100, 1'b1);
        expect_cycle("sw0_after", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        // threshold: 3-cycle pulse filtered, 4-cycle pulse passes
        bus.raw_in = 6'b010011;
        hold("thr3_pulse", 3, 6'b000000);
        bus.raw_in = 6'b000011;
        hold("thr3_tail", 8, 6'b000000);
        bus.raw_in = 6'b010011;
        hold("thr4_pulse", 4, 6'b000000);
        bus.raw_in = 6'b000011;
        hold("thr4_pre", 1, 6'b000000);
        expect_cycle("thr4_rise", 6'b010000, 6'b010000, 6'b000000, 1'b1);
        hold("thr4_high", 3, 6'b010000);
        expect_cycle("thr4_fall", 6'b000000, 6'b000000, 6'b010000, 1'b1);
        expect_cycle("thr4_after", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        // simultaneous rise on bits 5 and 2, then simultaneous fall
        bus.raw_in = 6'b100111;
        hold("simul_wait", 5, 6'b000000);
        expect_cycle("simul_rise", 6'b100100, 6'b100100, 6'b000000, 1'b1);
        expect_cycle("simul_after", 6'b100100, 6'b000000, 6'b000000, 1'b0);
        bus.raw_in = 6'b000011;
        hold("simul_off_wait", 5, 6'b100100);
        expect_cycle("simul_fall", 6'b000000, 6'b000000, 6'b100100, 1'b1);
        expect_cycle("simul_fall_after", 6'b000000, 6'b000000, 6'b000000, 1'b0);

        // reset mid-debounce: bit 5 settled high, bit 3 counting when reset hits
        bus.raw_in = 6'b100011;
        hold("pre_rst_wait", 5, 6'b000000);
        expect_cycle("pre_rst_rise", 6'b100000, 6'b100000, 6'b000000, 1'b1);
        expect_cycle("pre_rst_after", 6'b100000, 6'b000000, 6'b000000, 1'b0);
        bus.raw_in = 6'b101011;
        hold("mid_count", 4, 6'b100000);
        reset = 1'b1;
        #1;
        chk("reset_async", outs_s(), 19'h00000);
        hold("reset_held", 2, 6'b000000);
        reset = 1'b0;
        hold("post_rst_wait", 5, 6'b000000);
        expect_cycle("post_rst_rise", 6'b101000, 6'b101000, 6'b000000, 1'b1);
        expect_cycle("post_rst_after", 6'b101000, 6'b000000, 6'b000000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
